guess_scorer: RTL

- Consumer side of the master pattern: reads the four loaded master slots, accepts a player's guess into four guess slots, and scores it with a multi-cycle scan.
- Reports exact matches (right shape, right slot) and shape-only matches (right shape, wrong slot).
- Tracks the guess count and raises win and game-over flags.
- Sits beside the master loader and drives the score display and game-control logic.

---
 rtl/scorer_pkg.sv | 23 ++
 rtl/edge_pulse.sv | 28 ++
 rtl/guess_scorer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/scorer_pkg.sv
// rtl/scorer_pkg.sv - shared types, constants and helpers for the guess scorer
package scorer_pkg;

    localparam int SHAPE_W_DEF = 3;
    localparam int NUM_SLOTS   = 4;

    typedef logic [SHAPE_W_DEF-1:0] shape_t;

    localparam shape_t SHAPE_NONE = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXACT   = 2'd1,
        PARTIAL = 2'd2,
        DONE    = 2'd3
    } score_state_t;

    // Number of set bits in a four-slot match mask
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - two-flop synchroniser with registered rising-edge pulse
module edge_pulse (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronise the raw button, then emit one registered pulse per rising edge
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/guess_scorer.sv
// rtl/guess_scorer.sv - loads a four-slot guess and scores it against the master pattern
module guess_scorer
    import scorer_pkg::*;
#(
    parameter int MAX_GUESSES = 8,
    parameter int SHAPE_W     = SHAPE_W_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               resetMaster,
    input  logic [SHAPE_W-1:0] master0,
    input  logic [SHAPE_W-1:0] master1,
    input  logic [SHAPE_W-1:0] master2,
    input  logic [SHAPE_W-1:0] master3,
    input  logic               masterLoaded,
    input  logic               gamePlaying,
    input  logic [SHAPE_W-1:0] GuessShape,
    input  logic [1:0]         GuessLocation,
    input  logic               LoadGuessNow,
    input  logic               ScoreGuess,
    output logic [SHAPE_W-1:0] guess0,
    output logic [SHAPE_W-1:0] guess1,
    output logic [SHAPE_W-1:0] guess2,
    output logic [SHAPE_W-1:0] guess3,
    output logic               guessLoaded,
    output logic [2:0]         numZzz,
    output logic [2:0]         numZnarly,
    output logic               scoreValid,
    output logic [3:0]         guessCount,
    output logic               gameWon,
    output logic               gameOver,
    output logic               busy
);

    localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);
    localparam logic [SHAPE_W-1:0] EMPTY = SHAPE_W'(SHAPE_NONE);

    logic load_pulse;
    logic score_pulse;

    score_state_t state;

    logic [SHAPE_W-1:0] guess_r  [NUM_SLOTS];
    logic [SHAPE_W-1:0] master_a [NUM_SLOTS];

    logic [3:0] exact;
    logic [3:0] used_g;
    logic [3:0] used_m;
    logic [3:0] pidx;
    logic [1:0] pi;
    logic [1:0] pj;
    logic [2:0] zzz_acc;
    logic [2:0] znarly_acc;
    logic [3:0] count_next;
    logic       won_next;
    logic       load_ok;
    logic       score_ok;

    edge_pulse u_load_edge (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .din      (LoadGuessNow),
        .pulse    (load_pulse)
    );

    edge_pulse u_score_edge (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .din      (ScoreGuess),
        .pulse    (score_pulse)
    );

    // Gather the master slots and publish the guess slots
    always_comb begin
        master_a[0] = master0;
        master_a[1] = master1;
        master_a[2] = master2;
        master_a[3] = master3;
        guess0      = guess_r[0];
        guess1      = guess_r[1];
        guess2      = guess_r[2];
        guess3      = guess_r[3];
    end

    // Per-slot exact matches, full-guess flag and busy indication
    always_comb begin
        guessLoaded = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            exact[i] = (guess_r[i] == master_a[i]);
            if (guess_r[i] == EMPTY) begin
                guessLoaded = 1'b0;
            end
        end
        busy = (state != IDLE);
    end

    // Acceptance conditions, scan indices and the values committed at DONE
    always_comb begin
        load_ok    = load_pulse && gamePlaying && masterLoaded && !gameOver
                     && (guess_r[GuessLocation] == EMPTY);
        score_ok   = score_pulse && gamePlaying && guessLoaded && !gameOver;
        pi         = pidx[3:2];
        pj         = pidx[1:0];
        count_next = (guessCount < MAX_G) ? guessCount + 4'd1 : guessCount;
        won_next   = gameWon | (zzz_acc == 3'd4);
    end

    // Guess storage, scoring FSM and game bookkeeping
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) guess_r[i] <= EMPTY;
            used_g     <= '0;
            used_m     <= '0;
            pidx       <= '0;
            zzz_acc    <= '0;
            znarly_acc <= '0;
            numZzz     <= '0;
            numZnarly  <= '0;
            scoreValid <= 1'b0;
            guessCount <= '0;
            gameWon    <= 1'b0;
            gameOver   <= 1'b0;
        end else if (resetMaster) begin
            state      <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) guess_r[i] <= EMPTY;
            used_g     <= '0;
            used_m     <= '0;
            pidx       <= '0;
            zzz_acc    <= '0;
            znarly_acc <= '0;
            numZzz     <= '0;
            numZnarly  <= '0;
            scoreValid <= 1'b0;
            guessCount <= '0;
            gameWon    <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            scoreValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        guess_r[GuessLocation] <= GuessShape;
                    end
                    if (score_ok) begin
                        state <= EXACT;
                    end
                end
                EXACT: begin
                    // Exact hits consume their guess and master slot before the pair scan
                    used_g     <= exact;
                    used_m     <= exact;
                    zzz_acc    <= popcount4(exact);
                    znarly_acc <= '0;
                    pidx       <= '0;
                    state      <= PARTIAL;
                end
                PARTIAL: begin
                    if (!used_g[pi] && !used_m[pj] && (guess_r[pi] == master_a[pj])) begin
                        used_g[pi] <= 1'b1;
                        used_m[pj] <= 1'b1;
                        znarly_acc <= znarly_acc + 3'd1;
                    end
                    pidx <= pidx + 4'd1;
                    if (pidx == 4'd15) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    numZzz     <= zzz_acc;
                    numZnarly  <= znarly_acc;
                    scoreValid <= 1'b1;
                    for (int i = 0; i < NUM_SLOTS; i++) guess_r[i] <= EMPTY;
                    guessCount <= count_next;
                    gameWon    <= won_next;
                    gameOver   <= won_next || (count_next == MAX_G);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
